// File: rtl/multi_port_queue_bank_if.sv
// Ingress/egress bus of the queue bank: packetizer streams in, scheduler flags and head packet out.
// The master drives packets, thresholds and the scheduler controls; the slave is the bank.
interface multi_port_queue_bank_if #(
  parameter int NUMBER_OF_PORTS  = 2,
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int DATA_SIZE        = 678,
  parameter int QUEUE_LENGTH     = 16,
  parameter int REGISTER_SIZE    = 32
);
  localparam int QW = $clog2(NUMBER_OF_QUEUES);
  localparam int CW = $clog2(QUEUE_LENGTH) + 1;

  logic [NUMBER_OF_PORTS*DATA_SIZE-1:0]      in_packet;
  logic [NUMBER_OF_PORTS-1:0]                in_valid;
  logic [NUMBER_OF_PORTS*QW-1:0]             in_id;
  logic [NUMBER_OF_PORTS-1:0]                in_ready;
  logic [NUMBER_OF_QUEUES*REGISTER_SIZE-1:0] high_threshold;
  logic [NUMBER_OF_QUEUES*REGISTER_SIZE-1:0] low_threshold;
  logic [QW-1:0]                             select_id;
  logic                                      consume;
  logic [DATA_SIZE-1:0]                      out_packet;
  logic [NUMBER_OF_QUEUES-1:0]               empty;
  logic [NUMBER_OF_QUEUES-1:0]               full;
  logic [NUMBER_OF_QUEUES-1:0]               last_elem;
  logic [NUMBER_OF_QUEUES*CW-1:0]            occupancy;
  logic [NUMBER_OF_QUEUES-1:0]               kill_the_core;

  modport master (
    output in_packet, in_valid, in_id, high_threshold, low_threshold, select_id, consume,
    input  in_ready, out_packet, empty, full, last_elem, occupancy, kill_the_core
  );

  modport slave (
    input  in_packet, in_valid, in_id, high_threshold, low_threshold, select_id, consume,
    output in_ready, out_packet, empty, full, last_elem, occupancy, kill_the_core
  );
endinterface

// File: rtl/multi_port_queue_bank.sv
// Bank of per-queue FIFOs fed by several packetizer ports with fixed-priority collision arbitration,
// registered occupancy flags, hysteretic overload flags and a registered head-of-queue output.
module multi_port_queue_bank #(
  parameter int NUMBER_OF_PORTS  = 2,
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int DATA_SIZE        = 678,
  parameter int QUEUE_LENGTH     = 16,
  parameter int REGISTER_SIZE    = 32
) (
  input logic                  clock,
  input logic                  reset,
  multi_port_queue_bank_if.slave bus
);
  localparam int NP = NUMBER_OF_PORTS;
  localparam int NQ = NUMBER_OF_QUEUES;
  localparam int DS = DATA_SIZE;
  localparam int RS = REGISTER_SIZE;
  localparam int QW = $clog2(NQ);
  localparam int CW = $clog2(QUEUE_LENGTH) + 1;
  localparam int PW = $clog2(QUEUE_LENGTH);

  logic [DS-1:0] mem_q [NQ][QUEUE_LENGTH];
  logic [PW-1:0] wptr_q [NQ];
  logic [PW-1:0] wptr_d [NQ];
  logic [PW-1:0] rptr_q [NQ];
  logic [PW-1:0] rptr_d [NQ];
  logic [CW-1:0] count_q [NQ];
  logic [CW-1:0] count_d [NQ];
  logic [NQ-1:0] empty_q, empty_d, full_q, full_d, last_q, last_d, kill_q, kill_d;
  logic [DS-1:0] out_q, out_d;
  logic [NP-1:0] ready;
  logic [NQ-1:0] push_en, pop_en;
  logic [DS-1:0] push_data [NQ];

  // A port is refused when its queue is full or a lower-indexed valid port targets the same queue.
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional write, so no latch is inferred.
    ready = '0;
    for (int p = 0; p < NP; p++) begin
      ready[p] = reset && !full_q[bus.in_id[p*QW +: QW]];
      for (int k = 0; k < p; k++) begin
        if (bus.in_valid[k] && (bus.in_id[k*QW +: QW] == bus.in_id[p*QW +: QW])) ready[p] = 1'b0;
      end
    end
  end

  // Arbitration guarantees at most one accepted port per queue, so the routing below never overlaps.
  always_comb begin
    push_en = '0;
    pop_en  = '0;
    for (int q = 0; q < NQ; q++) push_data[q] = '0;
    for (int p = 0; p < NP; p++) begin
      if (bus.in_valid[p] && ready[p]) begin
        push_en[bus.in_id[p*QW +: QW]]   = 1'b1;
        push_data[bus.in_id[p*QW +: QW]] = bus.in_packet[p*DS +: DS];
      end
    end
    if (bus.consume && !empty_q[bus.select_id]) pop_en[bus.select_id] = 1'b1;
  end

  always_comb begin
    empty_d = '0;
    full_d  = '0;
    last_d  = '0;
    kill_d  = '0;
    for (int q = 0; q < NQ; q++) begin
      wptr_d[q]  = wptr_q[q] + PW'(push_en[q]);
      rptr_d[q]  = rptr_q[q] + PW'(pop_en[q]);
      count_d[q] = count_q[q] + CW'(push_en[q]) - CW'(pop_en[q]);
      empty_d[q] = (count_d[q] == '0);
      full_d[q]  = (count_d[q] == CW'(QUEUE_LENGTH));
      last_d[q]  = (count_d[q] == CW'(1));
      // Overload flag: set wins over clear, holds in between, disabled by a zero high level.
      if (bus.high_threshold[q*RS +: RS] == '0)                         kill_d[q] = 1'b0;
      else if (RS'(count_d[q]) >= bus.high_threshold[q*RS +: RS])       kill_d[q] = 1'b1;
      else if (RS'(count_d[q]) <= bus.low_threshold[q*RS +: RS])        kill_d[q] = 1'b0;
      else                                                              kill_d[q] = kill_q[q];
    end
    out_d = empty_q[bus.select_id] ? '0 : mem_q[bus.select_id][rptr_q[bus.select_id]];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int q = 0; q < NQ; q++) begin
        wptr_q[q]  <= '0;
        rptr_q[q]  <= '0;
        count_q[q] <= '0;
      end
      empty_q <= '1;
      full_q  <= '0;
      last_q  <= '0;
      kill_q  <= '0;
      out_q   <= '0;
    end else begin
      for (int q = 0; q < NQ; q++) begin
        wptr_q[q]  <= wptr_d[q];
        rptr_q[q]  <= rptr_d[q];
        count_q[q] <= count_d[q];
      end
      empty_q <= empty_d;
      full_q  <= full_d;
      last_q  <= last_d;
      kill_q  <= kill_d;
      out_q   <= out_d;
    end
  end

  // NOTE: packet storage is deliberately not reset; pointers and counts decide which entries are live.
  always_ff @(posedge clock) begin
    for (int q = 0; q < NQ; q++) begin
      if (push_en[q]) mem_q[q][wptr_q[q]] <= push_data[q];
    end
  end

  always_comb begin
    bus.occupancy = '0;
    for (int q = 0; q < NQ; q++) bus.occupancy[q*CW +: CW] = count_q[q];
  end

  assign bus.in_ready      = ready;
  assign bus.out_packet    = out_q;
  assign bus.empty         = empty_q;
  assign bus.full          = full_q;
  assign bus.last_elem     = last_q;
  assign bus.kill_the_core = kill_q;
endmodule

// File: tb/tb_multi_port_queue_bank.sv
// Directed bench for multi_port_queue_bank: a queue-based reference model checked every cycle,
// plus literal expectations for collisions, full, hysteresis, wrap/order, edge cases and async reset.
module tb_multi_port_queue_bank;
  localparam int NP = 2;
  localparam int NQ = 4;
  localparam int DS = 678;
  localparam int QL = 16;
  localparam int RS = 32;
  localparam int QW = 2;
  localparam int CW = 5;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  multi_port_queue_bank_if #(.NUMBER_OF_PORTS(NP), .NUMBER_OF_QUEUES(NQ), .DATA_SIZE(DS),
                             .QUEUE_LENGTH(QL), .REGISTER_SIZE(RS)) bus ();

  multi_port_queue_bank #(.NUMBER_OF_PORTS(NP), .NUMBER_OF_QUEUES(NQ), .DATA_SIZE(DS),
                          .QUEUE_LENGTH(QL), .REGISTER_SIZE(RS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [767:0] act, input logic [767:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one SystemVerilog queue of packets per hardware queue.
  logic [DS-1:0] mq [NQ][$];
  logic [NQ-1:0] m_kill = '0;
  logic [DS-1:0] m_out  = '0;

  function automatic logic [NP-1:0] model_ready();
    logic [NP-1:0] r;
    r = '0;
    if (reset) begin
      for (int p = 0; p < NP; p++) begin
        int  id;
        bit  taken;
        id    = int'(bus.in_id[p*QW +: QW]);
        taken = 1'b0;
        for (int k = 0; k < p; k++)
          if (bus.in_valid[k] && int'(bus.in_id[k*QW +: QW]) == id) taken = 1'b1;
        r[p] = !taken && (mq[id].size() < QL);
      end
    end
    return r;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int q = 0; q < NQ; q++) mq[q].delete();
      m_kill = '0;
      m_out  = '0;
    end else begin
      logic [NP-1:0] acc;
      int            sel;
      acc   = model_ready() & bus.in_valid;
      sel   = int'(bus.select_id);
      m_out = (mq[sel].size() > 0) ? mq[sel][0] : '0;
      if (bus.consume && mq[sel].size() > 0) void'(mq[sel].pop_front());
      for (int p = 0; p < NP; p++)
        if (acc[p]) mq[int'(bus.in_id[p*QW +: QW])].push_back(bus.in_packet[p*DS +: DS]);
      for (int q = 0; q < NQ; q++) begin
        longint unsigned n, hi, lo;
        n  = mq[q].size();
        hi = bus.high_threshold[q*RS +: RS];
        lo = bus.low_threshold[q*RS +: RS];
        if (hi == 0)       m_kill[q] = 1'b0;
        else if (n >= hi)  m_kill[q] = 1'b1;
        else if (n <= lo)  m_kill[q] = 1'b0;
      end
    end
  end

  function automatic logic [NQ*CW-1:0] m_occ();
    logic [NQ*CW-1:0] v;
    for (int q = 0; q < NQ; q++) v[q*CW +: CW] = CW'(mq[q].size());
    return v;
  endfunction

  function automatic logic [NQ-1:0] m_flag(input int level);
    logic [NQ-1:0] v;
    for (int q = 0; q < NQ; q++) v[q] = (mq[q].size() == level);
    return v;
  endfunction

  always @(negedge clock) begin
    check("in_ready",      bus.in_ready,      model_ready());
    check("out_packet",    bus.out_packet,    m_out);
    check("empty",         bus.empty,         m_flag(0));
    check("full",          bus.full,          m_flag(QL));
    check("last_elem",     bus.last_elem,     m_flag(1));
    check("occupancy",     bus.occupancy,     m_occ());
    check("kill_the_core", bus.kill_the_core, m_kill);
  end

  task automatic next();
    @(posedge clock);
    #1;
  endtask

  task automatic look();
    @(negedge clock);
    #1;
  endtask

  task automatic offer(input int p, input logic v, input int id, input logic [DS-1:0] d);
    bus.in_valid[p]            = v;
    bus.in_id[p*QW +: QW]      = QW'(id);
    bus.in_packet[p*DS +: DS]  = d;
  endtask

  function automatic logic [CW-1:0] occ_of(input int q);
    logic [NQ*CW-1:0] v;
    v = bus.occupancy;
    return v[q*CW +: CW];
  endfunction

  int seen [40];

  initial begin
    int  k, got;
    bit  acc, prev_pop;
    bus.in_packet      = '0;
    bus.in_valid       = '0;
    bus.in_id          = '0;
    bus.select_id      = '0;
    bus.consume        = 1'b0;
    bus.high_threshold = {32'd10, 32'd0, 32'd12, 32'd0};
    bus.low_threshold  = {32'd2,  32'd0, 32'd4,  32'd0};

    // Reset holds ready low even with offers pending.
    bus.in_valid = 2'b11;
    look();
    check("rst_ready", bus.in_ready, 2'b00);
    check("rst_empty", bus.empty, 4'hF);
    check("rst_occ",   bus.occupancy, '0);
    next();
    bus.in_valid = '0;
    next();
    reset = 1'b1;

    // Collision on queue 2: port 0 wins, port 1 retries.
    offer(0, 1'b1, 2, 'hA1);
    offer(1, 1'b1, 2, 'hB2);
    look();
    check("coll_ready0", bus.in_ready, 2'b01);
    next();
    offer(0, 1'b0, 0, '0);
    look();
    check("coll_ready1", bus.in_ready[1], 1'b1);
    next();
    bus.in_valid = '0;
    look();
    check("coll_occ2", occ_of(2), 5'd2);
    bus.select_id = 2'd2;
    bus.consume   = 1'b1;
    next();
    look();
    check("coll_out_a", bus.out_packet, 'hA1);
    next();
    look();
    check("coll_out_b", bus.out_packet, 'hB2);
    bus.consume = 1'b0;
    next();
    look();
    check("coll_out_empty", bus.out_packet, '0);
    check("coll_empty2", bus.empty[2], 1'b1);

    // Fill queue 0, then push+pop while full.
    for (int i = 0; i < 16; i++) begin
      offer(0, 1'b1, 0, DS'('h100 + i));
      next();
    end
    offer(0, 1'b1, 0, 'h1FF);
    look();
    check("full_flag0",  bus.full[0], 1'b1);
    check("full_ready0", bus.in_ready[0], 1'b0);
    check("full_kill0",  bus.kill_the_core[0], 1'b0);
    next();
    bus.select_id = 2'd0;
    bus.consume   = 1'b1;
    next();
    bus.consume = 1'b0;
    look();
    check("full_pop_occ",   occ_of(0), 5'd15);
    check("full_pop_ready", bus.in_ready[0], 1'b1);
    next();
    offer(0, 1'b0, 0, '0);
    bus.consume = 1'b1;
    repeat (16) next();
    bus.consume = 1'b0;
    look();
    check("full_drained", bus.empty[0], 1'b1);

    // Hysteresis on queue 1: set at 12, hold at 5, clear at 4.
    for (int i = 0; i < 11; i++) begin
      offer(1, 1'b1, 1, DS'('h200 + i));
      next();
    end
    offer(1, 1'b0, 1, '0);
    look();
    check("hyst_kill_11", bus.kill_the_core[1], 1'b0);
    offer(1, 1'b1, 1, 'h20B);
    next();
    offer(1, 1'b0, 1, '0);
    look();
    check("hyst_kill_12", bus.kill_the_core[1], 1'b1);
    bus.select_id = 2'd1;
    bus.consume   = 1'b1;
    repeat (7) next();
    bus.consume = 1'b0;
    look();
    check("hyst_occ_5",  occ_of(1), 5'd5);
    check("hyst_kill_5", bus.kill_the_core[1], 1'b1);
    bus.consume = 1'b1;
    next();
    bus.consume = 1'b0;
    look();
    check("hyst_kill_4", bus.kill_the_core[1], 1'b0);

    // Consume on empty queue 2 changes nothing.
    bus.select_id = 2'd2;
    bus.consume   = 1'b1;
    next();
    bus.consume = 1'b0;
    look();
    check("empty_pop_occ2", occ_of(2), 5'd0);
    check("empty_pop_occ1", occ_of(1), 5'd4);

    // Push to 5, then push+pop at 5 stays 5.
    offer(0, 1'b1, 1, 'h300);
    next();
    offer(0, 1'b1, 1, 'h301);
    bus.select_id = 2'd1;
    bus.consume   = 1'b1;
    next();
    offer(0, 1'b0, 0, '0);
    bus.consume = 1'b0;
    look();
    check("pushpop_occ_5", occ_of(1), 5'd5);
    bus.consume = 1'b1;
    repeat (5) next();
    bus.consume = 1'b0;

    // Stream 40 packets through queue 3 with alternating ports and wrap-around.
    bus.select_id = 2'd3;
    k = 0;
    got = 0;
    prev_pop = 1'b0;
    for (int c = 0; c < 400 && got < 40; c++) begin
      bus.in_valid = '0;
      if (k < 40) offer(k % 2, 1'b1, 3, DS'(k));
      bus.consume = (c >= 16);
      look();
      if (prev_pop) begin
        seen[got] = int'(bus.out_packet[31:0]);
        got++;
      end
      if (c == 1) check("wrap_last_1", bus.last_elem[3], 1'b1);
      if (c == 16) begin
        check("wrap_full_16", bus.full[3], 1'b1);
        check("wrap_occ_16",  occ_of(3), 5'd16);
      end
      acc      = (k < 40) && bus.in_ready[k % 2];
      prev_pop = bus.consume && !bus.empty[3];
      next();
      if (acc) k++;
    end
    bus.in_valid = '0;
    bus.consume  = 1'b0;
    check("wrap_count", got, 40);
    for (int i = 0; i < 40; i++) check($sformatf("wrap_seq_%0d", i), seen[i], i);
    look();
    check("wrap_empty_0", bus.empty[3], 1'b1);

    // Build 7/16/0/3 using both ports on different queues in the same cycles.
    for (int i = 0; i < 16; i++) begin
      offer(0, 1'b1, 1, DS'('h500 + i));
      if (i < 7)       offer(1, 1'b1, 0, DS'('h600 + i));
      else if (i < 10) offer(1, 1'b1, 3, DS'('h700 + i));
      else             offer(1, 1'b0, 0, '0);
      next();
    end
    bus.in_valid  = '0;
    bus.select_id = 2'd1;
    next();
    look();
    check("pre_rst_occ",  bus.occupancy, {5'd3, 5'd0, 5'd16, 5'd7});
    check("pre_rst_kill", bus.kill_the_core, 4'b0010);
    check("pre_rst_out",  bus.out_packet, 'h500);
    next();
    #1;
    reset = 1'b0;
    #1;
    check("async_empty", bus.empty, 4'hF);
    check("async_full",  bus.full, 4'h0);
    check("async_last",  bus.last_elem, 4'h0);
    check("async_occ",   bus.occupancy, '0);
    check("async_kill",  bus.kill_the_core, 4'h0);
    check("async_out",   bus.out_packet, '0);
    next();
    reset = 1'b1;
    offer(1, 1'b1, 2, 'h777);
    next();
    offer(1, 1'b0, 0, '0);
    bus.select_id = 2'd2;
    look();
    check("post_rst_occ2",  occ_of(2), 5'd1);
    check("post_rst_last2", bus.last_elem[2], 1'b1);
    check("post_rst_occ1",  occ_of(1), 5'd0);
    next();
    look();
    check("post_rst_out", bus.out_packet, 'h777);
    next();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
